cam_pixel_capture: RTL and testbench

Parametrised OV7670 capture block: samples the camera byte stream (RGB565, two bytes per pixel) in the `pclk` domain, converts each pixel to a selectable output format, and emits frame-buffer write transactions (address, data, write strobe). Successor to the fixed RGB332 converter; adds selectable output format, a window limit, address generation, frame framing via VSYNC, a capture enable and error reporting. Sits between the camera pins and the frame-buffer RAM write port.

---
 rtl/cam_pixel_capture_if.sv | 26 ++
 rtl/cam_pixel_capture.sv | 137 +++++++++++++
 tb/tb_cam_pixel_capture.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cam_pixel_capture_if.sv
// cam_pixel_capture_if
//   Bundles the camera pin group (vsync, href, in_dt) and the frame-buffer
//   write port (mem_addr, mem_data, mem_wr) used by cam_pixel_capture.
//   Parameters:
//     OUT_MODE  pixel format, sets the mem_data width DW (0:8, 1:12, 2:16).
//               It must match the OUT_MODE of the attached capture block.
//     ADDR_W    frame-buffer address width.
//   Modports:
//     master    camera / RAM side: drives the camera pins, sees the writes.
//     slave     capture block: reads the camera pins, drives the writes.
interface cam_pixel_capture_if #(
   parameter int OUT_MODE = 0,
   parameter int ADDR_W   = 15
);
   localparam int DW = (OUT_MODE == 0) ? 8 : (OUT_MODE == 1) ? 12 : 16;

   logic              vsync;
   logic              href;
   logic [7:0]        in_dt;
   logic [ADDR_W-1:0] mem_addr;
   logic [DW-1:0]     mem_data;
   logic              mem_wr;

   modport master (output vsync, href, in_dt, input mem_addr, mem_data, mem_wr);
   modport slave  (input vsync, href, in_dt, output mem_addr, mem_data, mem_wr);
endinterface

// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture
//   Captures an OV7670 RGB565 byte stream (two bytes per pixel) in the pclk
//   domain, converts each pixel to RGB332 / RGB444 / RGB565 and issues one
//   frame-buffer write per stored pixel. A frame is armed by capture_en at
//   the VSYNC falling edge and closed by the VSYNC rising edge.
//   Ports:
//     pclk        camera pixel clock, all logic on its rising edge
//     in_reset    synchronous active-high reset
//     capture_en  arm capture of the next frame (sampled at VSYNC fall only)
//     bus         camera pins in, registered write port out (addr/data/strobe)
//     frame_done  one-cycle pulse after a captured frame ends
//     busy        high while a frame is being captured
//     err_odd     sticky flag: a line ended on an odd byte count
module cam_pixel_capture #(
   parameter int OUT_MODE = 0,
   parameter int H_PIX    = 160,
   parameter int V_LINES  = 120,
   parameter int ADDR_W   = 15
) (
   input  logic                  pclk,
   input  logic                  in_reset,
   input  logic                  capture_en,
   cam_pixel_capture_if.slave    bus,
   output logic                  frame_done,
   output logic                  busy,
   output logic                  err_odd
);
   localparam int DW = (OUT_MODE == 0) ? 8 : (OUT_MODE == 1) ? 12 : 16;
   localparam int PW = $clog2(H_PIX + 1);
   localparam int LW = $clog2(V_LINES + 1);
   localparam logic [PW-1:0] H_MAX = PW'(H_PIX);
   localparam logic [LW-1:0] V_MAX = LW'(V_LINES);

   typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

   state_t          state, state_nxt;
   logic            vsync_q, href_q;
   logic            phase;
   logic [7:0]      hi;
   logic [PW-1:0]   pix_cnt;
   logic [LW-1:0]   line_cnt;
   logic            vs_fall, vs_rise, in_win, start;
   logic [4:0]      r5, b5;
   logic [5:0]      g6;
   logic [7:0]      c332;
   logic [11:0]     c444;
   logic [15:0]     c565;
   logic [DW-1:0]   conv;

   assign vs_fall = vsync_q & ~bus.vsync;
   assign vs_rise = ~vsync_q & bus.vsync;
   assign in_win  = (pix_cnt < H_MAX) && (line_cnt < V_MAX);
   assign start   = (state == IDLE) && vs_fall && capture_en;

   // Low byte comes straight from the pin on the second byte edge.
   assign r5   = hi[7:3];
   assign g6   = {hi[2:0], bus.in_dt[7:5]};
   assign b5   = bus.in_dt[4:0];
   assign c332 = {r5[4:2], g6[5:3], b5[4:3]};
   assign c444 = {r5[4:1], g6[5:2], b5[4:1]};
   assign c565 = {r5, g6, b5};
   assign conv = (OUT_MODE == 0) ? DW'(c332) : (OUT_MODE == 1) ? DW'(c444) : DW'(c565);

   always_comb begin
      state_nxt  = state;
      frame_done = 1'b0;
      busy       = 1'b0;
      unique case (state)
         IDLE:    if (start) state_nxt = CAPTURE;
         CAPTURE: begin
            busy = 1'b1;
            if (vs_rise) state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (in_reset) begin
         state        <= IDLE;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         phase        <= 1'b0;
         hi           <= '0;
         pix_cnt      <= '0;
         line_cnt     <= '0;
         err_odd      <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_data <= '0;
         bus.mem_wr   <= 1'b0;
      end else begin
         state      <= state_nxt;
         vsync_q    <= bus.vsync;
         href_q     <= bus.href;
         bus.mem_wr <= 1'b0;
         // Address is shown pre-increment with its strobe and advances as
         // the strobe cycle closes.
         if (bus.mem_wr) bus.mem_addr <= bus.mem_addr + ADDR_W'(1);

         if (start) begin
            bus.mem_addr <= '0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            phase        <= 1'b0;
         end else if (state == CAPTURE) begin
            // Pixel assembly keeps running on the vsync rise edge; any half
            // pixel left over is discarded by the phase clear on next start.
            if (bus.href) begin
               if (!phase) begin
                  hi    <= bus.in_dt;
                  phase <= 1'b1;
               end else begin
                  phase <= 1'b0;
                  if (in_win) begin
                     bus.mem_wr   <= 1'b1;
                     bus.mem_data <= conv;
                  end
                  // Out-of-window pixels still count, saturating at H_PIX.
                  if (pix_cnt != H_MAX) pix_cnt <= pix_cnt + PW'(1);
               end
            end else if (href_q) begin
               // Line end; a dangling high byte is dropped and flagged.
               pix_cnt <= '0;
               if (line_cnt != V_MAX) line_cnt <= line_cnt + LW'(1);
               if (phase) begin
                  phase   <= 1'b0;
                  err_odd <= 1'b1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_cam_pixel_capture.sv
// tb_cam_pixel_capture
//   Drives one camera byte stream into four capture blocks:
//     0: RGB565 4x3, 1: RGB332 4x3, 2: RGB444 4x3, 3: RGB565 4x2.
//   A frame-level model pushes expected {addr,data} writes per instance and
//   a negedge monitor pops and compares every write strobe.
module tb_cam_pixel_capture;
   localparam int ND = 4;
   localparam int H  = 4;

   typedef struct packed {
      logic [14:0] addr;
      logic [15:0] data;
   } exp_t;

   int vl [ND] = '{3, 3, 3, 2};
   int md [ND] = '{2, 0, 1, 2};

   logic       pclk = 1'b0;
   logic       rst, cen, vs, hr;
   logic [7:0] dt;

   logic [ND-1:0] fd, bz, eo, wr;
   logic [14:0]   ad [ND];
   logic [15:0]   dd [ND];

   int   checks = 0;
   int   errors = 0;
   exp_t exq [ND][$];
   int   wr_cnt [ND] = '{0, 0, 0, 0};
   int   fd_cnt [ND] = '{0, 0, 0, 0};
   int   wr0 [ND], fd0 [ND];
   int   m_pix [ND], m_line [ND], m_addr [ND];
   logic m_active = 1'b0;
   logic m_err = 1'b0;

   always #5 pclk = ~pclk;

   cam_pixel_capture_if #(.OUT_MODE(2), .ADDR_W(15)) if_a ();
   cam_pixel_capture_if #(.OUT_MODE(0), .ADDR_W(15)) if_b ();
   cam_pixel_capture_if #(.OUT_MODE(1), .ADDR_W(15)) if_c ();
   cam_pixel_capture_if #(.OUT_MODE(2), .ADDR_W(15)) if_d ();

   assign if_a.vsync = vs;  assign if_a.href = hr;  assign if_a.in_dt = dt;
   assign if_b.vsync = vs;  assign if_b.href = hr;  assign if_b.in_dt = dt;
   assign if_c.vsync = vs;  assign if_c.href = hr;  assign if_c.in_dt = dt;
   assign if_d.vsync = vs;  assign if_d.href = hr;  assign if_d.in_dt = dt;

   assign wr = {if_d.mem_wr, if_c.mem_wr, if_b.mem_wr, if_a.mem_wr};
   assign ad[0] = if_a.mem_addr;
   assign ad[1] = if_b.mem_addr;
   assign ad[2] = if_c.mem_addr;
   assign ad[3] = if_d.mem_addr;
   assign dd[0] = if_a.mem_data;
   assign dd[1] = {8'h00, if_b.mem_data};
   assign dd[2] = {4'h0, if_c.mem_data};
   assign dd[3] = if_d.mem_data;

   cam_pixel_capture #(.OUT_MODE(2), .H_PIX(4), .V_LINES(3), .ADDR_W(15)) dut_a (
      .pclk(pclk), .in_reset(rst), .capture_en(cen), .bus(if_a.slave),
      .frame_done(fd[0]), .busy(bz[0]), .err_odd(eo[0]));
   cam_pixel_capture #(.OUT_MODE(0), .H_PIX(4), .V_LINES(3), .ADDR_W(15)) dut_b (
      .pclk(pclk), .in_reset(rst), .capture_en(cen), .bus(if_b.slave),
      .frame_done(fd[1]), .busy(bz[1]), .err_odd(eo[1]));
   cam_pixel_capture #(.OUT_MODE(1), .H_PIX(4), .V_LINES(3), .ADDR_W(15)) dut_c (
      .pclk(pclk), .in_reset(rst), .capture_en(cen), .bus(if_c.slave),
      .frame_done(fd[2]), .busy(bz[2]), .err_odd(eo[2]));
   cam_pixel_capture #(.OUT_MODE(2), .H_PIX(4), .V_LINES(2), .ADDR_W(15)) dut_d (
      .pclk(pclk), .in_reset(rst), .capture_en(cen), .bus(if_d.slave),
      .frame_done(fd[3]), .busy(bz[3]), .err_odd(eo[3]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] conv(input int mode, input logic [7:0] h, input logic [7:0] l);
      logic [15:0] w;
      w = {h, l};
      case (mode)
         0:       return {8'h00, w[15:13], w[10:8], w[4:3]};
         1:       return {4'h0, w[15:12], w[10:7], w[4:1]};
         default: return w;
      endcase
   endfunction

   // Scoreboard monitor: every strobe must match the oldest expected write.
   always @(negedge pclk) begin
      for (int d = 0; d < ND; d++) begin
         if (fd[d] === 1'b1) fd_cnt[d]++;
         if (wr[d] === 1'b1) begin
            exp_t e;
            wr_cnt[d]++;
            chk($sformatf("wr_expected_%0d", d), 32'(exq[d].size() > 0), 32'd1);
            if (exq[d].size() > 0) begin
               e = exq[d].pop_front();
               chk($sformatf("addr_%0d", d), 32'(ad[d]), 32'(e.addr));
               chk($sformatf("data_%0d", d), 32'(dd[d]), 32'(e.data));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic snapshot();
      for (int d = 0; d < ND; d++) begin
         wr0[d] = wr_cnt[d];
         fd0[d] = fd_cnt[d];
      end
   endtask

   task automatic check_zero(input string tag);
      for (int d = 0; d < ND; d++) begin
         chk({tag, "_wr"},   32'(wr[d]), 32'd0);
         chk({tag, "_addr"}, 32'(ad[d]), 32'd0);
         chk({tag, "_data"}, 32'(dd[d]), 32'd0);
         chk({tag, "_fd"},   32'(fd[d]), 32'd0);
         chk({tag, "_busy"}, 32'(bz[d]), 32'd0);
         chk({tag, "_err"},  32'(eo[d]), 32'd0);
      end
   endtask

   task automatic model_pixel(input logic [7:0] h, input logic [7:0] l);
      if (!m_active) return;
      for (int d = 0; d < ND; d++) begin
         if (m_pix[d] < H && m_line[d] < vl[d]) begin
            exq[d].push_back({15'(m_addr[d]), conv(md[d], h, l)});
            m_addr[d]++;
         end
         if (m_pix[d] < H) m_pix[d]++;
      end
   endtask

   task automatic frame_start(input logic c);
      cen = c;
      vs  = 1'b0;
      tick(1);
      m_active = c;
      for (int d = 0; d < ND; d++) begin
         m_pix[d] = 0; m_line[d] = 0; m_addr[d] = 0;
         chk("busy_start", 32'(bz[d]), 32'(c));
      end
      snapshot();
   endtask

   task automatic frame_end();
      vs = 1'b1;
      tick(4);
      for (int d = 0; d < ND; d++) begin
         chk($sformatf("frame_done_%0d", d), 32'(fd_cnt[d] - fd0[d]), m_active ? 32'd1 : 32'd0);
         chk($sformatf("busy_end_%0d", d), 32'(bz[d]), 32'd0);
         chk($sformatf("nwrites_%0d", d), 32'(wr_cnt[d] - wr0[d]), m_active ? 32'(m_addr[d]) : 32'd0);
         chk($sformatf("sb_empty_%0d", d), 32'(exq[d].size()), 32'd0);
         chk($sformatf("err_odd_%0d", d), 32'(eo[d]), 32'(m_err));
      end
      m_active = 1'b0;
   endtask

   task automatic send_line(input int nbytes, input logic first_red);
      logic [7:0] h, l;
      h = 8'h00; l = 8'h00;
      hr = 1'b1;
      for (int i = 0; i < nbytes; i++) begin
         if (i % 2 == 0) begin
            if (first_red && i == 0) begin h = 8'hF8; l = 8'h00; end
            else begin h = 8'($urandom); l = 8'($urandom); end
            dt = h;
         end else begin
            dt = l;
            model_pixel(h, l);
         end
         tick(1);
         if (first_red && i == 1) begin
            chk("red_wr",     32'(wr[0]), 32'd1);
            chk("red_addr",   32'(ad[0]), 32'd0);
            chk("red_rgb565", 32'(dd[0]), 32'hF800);
            chk("red_rgb332", 32'(dd[1]), 32'hE0);
            chk("red_rgb444", 32'(dd[2]), 32'hF00);
         end
      end
      hr = 1'b0;
      dt = 8'h00;
      tick(1);
      for (int d = 0; d < ND; d++) begin
         m_pix[d] = 0;
         if (m_line[d] < vl[d]) m_line[d]++;
      end
      if (m_active && (nbytes % 2 == 1)) m_err = 1'b1;
      tick(2);
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; vs = 1'b1; hr = 1'b0; dt = 8'h00;
      tick(3);
      check_zero("reset");
      rst = 1'b0;
      tick(2);

      // Full 4x3 frame, first pixel pure red.
      frame_start(1'b1);
      send_line(8, 1'b1);
      send_line(8, 1'b0);
      send_line(8, 1'b0);
      frame_end();

      // Over-size frame: 6 pixels x 4 lines.
      frame_start(1'b1);
      repeat (4) send_line(12, 1'b0);
      frame_end();
      chk("oversize_final_addr_d", 32'(ad[3]), 32'd8);

      // Odd line of 5 bytes, then a full line continuing at address 2.
      frame_start(1'b1);
      send_line(5, 1'b0);
      for (int d = 0; d < ND; d++) chk("err_after_odd", 32'(eo[d]), 32'd1);
      send_line(8, 1'b0);
      frame_end();

      // Not armed: frame ignored.
      frame_start(1'b0);
      send_line(8, 1'b0);
      send_line(8, 1'b0);
      frame_end();

      // Armed, then capture_en dropped mid-frame: frame still completes.
      frame_start(1'b1);
      cen = 1'b0;
      send_line(8, 1'b0);
      send_line(8, 1'b0);
      frame_end();

      // Reset after 3 pixels of a frame.
      frame_start(1'b1);
      hr = 1'b1;
      for (int p = 0; p < 3; p++) begin
         logic [7:0] h, l;
         h = 8'($urandom); l = 8'($urandom);
         dt = h; tick(1);
         dt = l; model_pixel(h, l); tick(1);
      end
      rst = 1'b1;
      dt  = 8'h5A;
      tick(1);
      check_zero("midreset");
      m_active = 1'b0;
      m_err    = 1'b0;
      snapshot();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dt = 8'($urandom);
         tick(1);
      end
      hr = 1'b0;
      tick(2);
      frame_end();

      // Next armed frame after the reset starts from address 0.
      frame_start(1'b1);
      send_line(4, 1'b0);
      frame_end();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
